// File: rtl/axi4s_uart_rx.sv
// UART receiver: 8N1 serial in, one-byte AXI4-Stream master out, with registered error pulses.
// Define AXI4S_UART_RX_PARITY_EN to receive 8E1 frames and get the rx_parity_err output.
module axi4s_uart_rx #(
    parameter int ACLK_FREQUENCY = 200000000,
    parameter int BAUD_RATE      = 9600
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       uart_rxd,
    output logic       rx_byte_tvalid,
    input  logic       rx_byte_tready,
    output logic [7:0] rx_byte_tdata,
    output logic       rx_frame_err,
    output logic       rx_overrun
`ifdef AXI4S_UART_RX_PARITY_EN
    ,
    output logic       rx_parity_err
`endif
);

    localparam int BIT_CNT  = (ACLK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CNT_W    = $clog2(BIT_CNT);

    generate
        if (BIT_CNT < 4) begin : g_bad_cfg
            $error("axi4s_uart_rx: BIT_CNT must be >= 4");
        end
    endgenerate

`ifdef AXI4S_UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t             state, state_nx;
    logic               rxd_m, rxd_s;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [2:0]         bit_idx, bit_idx_nx;
    logic [7:0]         shreg, shreg_nx;
    logic               expiry;
    logic               commit;
    logic               frame_bad;
`ifdef AXI4S_UART_RX_PARITY_EN
    logic               par_bit, par_bit_nx;
    logic               par_bad;
`endif

    assign expiry = (cnt == '0);

    always_ff @(posedge aclk) begin
        if (areset) begin
            rxd_m   <= 1'b1;
            rxd_s   <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef AXI4S_UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            rxd_m   <= uart_rxd;
            rxd_s   <= rxd_m;
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            shreg   <= shreg_nx;
`ifdef AXI4S_UART_RX_PARITY_EN
            par_bit <= par_bit_nx;
`endif
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        commit     = 1'b0;
        frame_bad  = 1'b0;
`ifdef AXI4S_UART_RX_PARITY_EN
        par_bit_nx = par_bit;
        par_bad    = 1'b0;
`endif
        if (state != IDLE && state != BREAK)
            cnt_nx = cnt - CNT_W'(1);

        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    cnt_nx   = CNT_W'(HALF_CNT - 1);
                    state_nx = START;
                end
            end
            START: begin
                if (expiry) begin
                    if (rxd_s) begin
                        state_nx = IDLE;
                    end else begin
                        cnt_nx     = CNT_W'(BIT_CNT - 1);
                        bit_idx_nx = '0;
                        state_nx   = DATA;
                    end
                end
            end
            DATA: begin
                if (expiry) begin
                    shreg_nx   = {rxd_s, shreg[7:1]};
                    cnt_nx     = CNT_W'(BIT_CNT - 1);
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef AXI4S_UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef AXI4S_UART_RX_PARITY_EN
            PARITY: begin
                if (expiry) begin
                    par_bit_nx = rxd_s;
                    cnt_nx     = CNT_W'(BIT_CNT - 1);
                    state_nx   = STOP;
                end
            end
`endif
            STOP: begin
                if (expiry) begin
                    if (rxd_s) begin
                        state_nx = IDLE;
`ifdef AXI4S_UART_RX_PARITY_EN
                        // even parity: data bits plus parity bit must XOR to zero
                        if (^{shreg, par_bit})
                            par_bad = 1'b1;
                        else
                            commit = 1'b1;
`else
                        commit = 1'b1;
`endif
                    end else begin
                        frame_bad = 1'b1;
                        state_nx  = BREAK;
                    end
                end
            end
            BREAK: begin
                // hold here until the line recovers so a stuck-low line cannot fake frames
                if (rxd_s)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rx_byte_tvalid <= 1'b0;
            rx_byte_tdata  <= 8'h00;
            rx_frame_err   <= 1'b0;
            rx_overrun     <= 1'b0;
`ifdef AXI4S_UART_RX_PARITY_EN
            rx_parity_err  <= 1'b0;
`endif
        end else begin
            rx_frame_err <= frame_bad;
            rx_overrun   <= 1'b0;
`ifdef AXI4S_UART_RX_PARITY_EN
            rx_parity_err <= par_bad;
`endif
            if (commit) begin
                // a full holding register that is not being drained keeps the old byte
                if (!rx_byte_tvalid || rx_byte_tready) begin
                    rx_byte_tdata  <= shreg;
                    rx_byte_tvalid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_byte_tvalid && rx_byte_tready) begin
                rx_byte_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4s_uart_rx.sv
// Directed bench for axi4s_uart_rx: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_axi4s_uart_rx;

    localparam int BIT = 10;
`ifdef AXI4S_UART_RX_PARITY_EN
    localparam int LAT_MIN = 104;
    localparam int LAT_MAX = 108;
    // tail of the reset-interrupted 0x77 frame: bit7 (0) acts as a start bit,
    // the parity bit (0) becomes data bit 0, idle-high fills the rest, parity 1 is even
    localparam logic [7:0] GARBAGE = 8'hFE;
`else
    localparam int LAT_MIN = 94;
    localparam int LAT_MAX = 98;
    // tail of the reset-interrupted 0x77 frame: bit7 (0) acts as a start bit, idle-high fills the byte
    localparam logic [7:0] GARBAGE = 8'hFF;
`endif

    logic       aclk;
    logic       areset;
    logic       uart_rxd;
    logic       rx_byte_tvalid;
    logic       rx_byte_tready;
    logic [7:0] rx_byte_tdata;
    logic       rx_frame_err;
    logic       rx_overrun;
`ifdef AXI4S_UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    axi4s_uart_rx #(
        .ACLK_FREQUENCY(100000000),
        .BAUD_RATE     (10000000)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .uart_rxd      (uart_rxd),
        .rx_byte_tvalid(rx_byte_tvalid),
        .rx_byte_tready(rx_byte_tready),
        .rx_byte_tdata (rx_byte_tdata),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun)
`ifdef AXI4S_UART_RX_PARITY_EN
        ,
        .rx_parity_err (rx_parity_err)
`endif
    );

    typedef struct {
        logic [7:0] data;
        int         start;
        bit         chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   hs_cnt = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    int   pe_cnt = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // monitor
    always @(negedge aclk) begin
        if (rx_frame_err) fe_cnt++;
        if (rx_overrun) ov_cnt++;
`ifdef AXI4S_UART_RX_PARITY_EN
        if (rx_parity_err) pe_cnt++;
`endif
        if (rx_byte_tvalid && rx_byte_tready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte actual=%02h required=none", rx_byte_tdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("tdata", int'(rx_byte_tdata), int'(e.data));
                if (e.chk_lat) begin
                    int lat;
                    lat = cyc - e.start;
                    checks++;
                    if (lat < LAT_MIN || lat > LAT_MAX) begin
                        errors++;
                        $display("FAIL latency actual=%0d required=%0d..%0d", lat, LAT_MIN, LAT_MAX);
                    end
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        uart_rxd = b;
        repeat (BIT) @(negedge aclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                              input bit expect_out, input bit chk_lat);
        if (expect_out) exp_q.push_back('{d, cyc, chk_lat});
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef AXI4S_UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`else
        if (par_flip) uart_rxd = 1'b1;
`endif
        drive_bit(stop);
    endtask

    initial begin
        logic [7:0] d77;
        areset         = 1'b1;
        uart_rxd       = 1'b1;
        rx_byte_tready = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_tvalid", int'(rx_byte_tvalid), 0);
        check("rst_tdata", int'(rx_byte_tdata), 0);
        check("rst_frame_err", int'(rx_frame_err), 0);
        check("rst_overrun", int'(rx_overrun), 0);
        areset = 1'b0;
        repeat (5) @(negedge aclk);

        // clean frame with latency check
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (30) @(negedge aclk);
        check("a5_drained", exp_q.size(), 0);
        check("a5_hs", hs_cnt, 1);
        check("a5_frame_err", fe_cnt, 0);
        check("a5_overrun", ov_cnt, 0);
        check("a5_parity_err", pe_cnt, 0);

        // short low glitch
        uart_rxd = 1'b0;
        repeat (3) @(negedge aclk);
        uart_rxd = 1'b1;
        repeat (40) @(negedge aclk);
        check("glitch_hs", hs_cnt, 1);
        check("glitch_frame_err", fe_cnt, 0);

        // bad stop bit, line held low, then recovery
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        uart_rxd = 1'b0;
        repeat (30) @(negedge aclk);
        uart_rxd = 1'b1;
        repeat (20) @(negedge aclk);
        send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (30) @(negedge aclk);
        check("ferr_count", fe_cnt, 1);
        check("ferr_drained", exp_q.size(), 0);
        check("ferr_hs", hs_cnt, 2);

        // overrun under backpressure
        rx_byte_tready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (30) @(negedge aclk);
        check("ovr_count", ov_cnt, 1);
        check("ovr_tvalid_held", int'(rx_byte_tvalid), 1);
        check("ovr_tdata_held", int'(rx_byte_tdata), 'h11);
        rx_byte_tready = 1'b1;
        repeat (5) @(negedge aclk);
        check("ovr_tvalid_drop", int'(rx_byte_tvalid), 0);
        check("ovr_drained", exp_q.size(), 0);
        check("ovr_hs", hs_cnt, 3);
        check("ovr_frame_err", fe_cnt, 1);

        // back-to-back frames, zero idle
        send_frame(8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (30) @(negedge aclk);
        check("b2b_drained", exp_q.size(), 0);
        check("b2b_hs", hs_cnt, 6);
        check("b2b_overrun", ov_cnt, 1);

        // reset mid-frame, with a held byte that reset must clear
        rx_byte_tready = 1'b0;
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge aclk);
        check("pre_rst_tvalid", int'(rx_byte_tvalid), 1);
        d77 = 8'h77;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d77[i]);
        uart_rxd = d77[4];
        repeat (5) @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        check("midrst_tvalid", int'(rx_byte_tvalid), 0);
        check("midrst_tdata", int'(rx_byte_tdata), 0);
        areset = 1'b0;
        rx_byte_tready = 1'b1;
        exp_q.push_back('{GARBAGE, cyc, 1'b0});
        repeat (4) @(negedge aclk);
        for (int i = 5; i < 8; i++) drive_bit(d77[i]);
`ifdef AXI4S_UART_RX_PARITY_EN
        drive_bit(^d77);
`endif
        drive_bit(1'b1);
        repeat (150) @(negedge aclk);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (30) @(negedge aclk);
        check("post_rst_drained", exp_q.size(), 0);
        check("post_rst_hs", hs_cnt, 8);
        check("post_rst_frame_err", fe_cnt, 1);
        check("post_rst_overrun", ov_cnt, 1);

`ifdef AXI4S_UART_RX_PARITY_EN
        // parity mismatch drops the byte
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (30) @(negedge aclk);
        check("par_err_count", pe_cnt, 1);
        check("par_hs", hs_cnt, 8);
        check("par_frame_err", fe_cnt, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
